// File: rtl/seq_muxn.sv
// Registered N-channel mux with fixed-select or round-robin arbitration and valid/ready flow.
// Optional out_parity output (even parity of out_data) when SEQ_MUXN_PARITY_EN is defined.
module seq_muxn #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned SEL_W    = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic [CHANNELS-1:0]       in_valid,
    output logic [CHANNELS-1:0]       in_ready,
    input  logic                      mode,
    input  logic [SEL_W-1:0]          sel,
    output logic [WIDTH-1:0]          out_data,
    output logic [SEL_W-1:0]          out_chan,
    output logic                      out_valid,
`ifdef SEQ_MUXN_PARITY_EN
    output logic                      out_parity,
`endif
    input  logic                      out_ready
);

    logic [WIDTH-1:0]    data_q;
    logic [SEL_W-1:0]    chan_q;
    logic                valid_q;
    logic [SEL_W-1:0]    ptr_q, ptr_d;

    logic                load;
    logic                accept;
    logic                grant_vld;
    logic [SEL_W-1:0]    grant_idx;
    logic [WIDTH-1:0]    grant_data;

    logic [CHANNELS-1:0] vscan;
    logic                fix_vld, hi_vld, lo_vld;
    logic [SEL_W-1:0]    fix_idx, hi_idx, lo_idx;

    assign load = ~valid_q | out_ready;

    // Round-robin is split into a search at/above ptr and a wrap-around search below it.
    always_comb begin
        vscan   = in_valid;
        fix_vld = 1'b0;
        fix_idx = '0;
        hi_vld  = 1'b0;
        hi_idx  = '0;
        lo_vld  = 1'b0;
        lo_idx  = '0;
        for (int unsigned k = 0; k < CHANNELS; k++) begin
            if (vscan[0]) begin
                if (SEL_W'(k) == sel) begin
                    fix_vld = 1'b1;
                    fix_idx = SEL_W'(k);
                end
                if (k >= 32'(ptr_q)) begin
                    if (!hi_vld) begin
                        hi_vld = 1'b1;
                        hi_idx = SEL_W'(k);
                    end
                end else if (!lo_vld) begin
                    lo_vld = 1'b1;
                    lo_idx = SEL_W'(k);
                end
            end
            vscan = vscan >> 1;
        end
    end

    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        if (!mode) begin
            grant_vld = fix_vld;
            grant_idx = fix_idx;
        end else begin
            grant_vld = hi_vld | lo_vld;
            grant_idx = hi_vld ? hi_idx : lo_idx;
        end
    end

    assign accept     = load & grant_vld;
    assign grant_data = WIDTH'(in_data >> (32'(grant_idx) * WIDTH));

    always_comb begin
        in_ready = '0;
        if (rst_n && accept) begin
            in_ready = CHANNELS'(1) << grant_idx;
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (mode && accept) begin
            ptr_d = (32'(grant_idx) == CHANNELS - 1) ? '0 : grant_idx + SEL_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q  <= '0;
            chan_q  <= '0;
            valid_q <= 1'b0;
            ptr_q   <= '0;
        end else begin
            ptr_q <= ptr_d;
            if (load) begin
                valid_q <= grant_vld;
                if (grant_vld) begin
                    data_q <= grant_data;
                    chan_q <= grant_idx;
                end
            end
        end
    end

`ifdef SEQ_MUXN_PARITY_EN
    logic parity_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            parity_q <= 1'b0;
        end else if (accept) begin
            parity_q <= ^grant_data;
        end
    end

    assign out_parity = parity_q;
`endif

    assign out_data  = data_q;
    assign out_chan  = chan_q;
    assign out_valid = valid_q;

endmodule

// File: tb/tb_seq_muxn.sv
// Scoreboard bench for seq_muxn: a 4-channel and a 3-channel instance driven with directed vectors.
// Expected beats are queued by the stimulus and popped by a negedge monitor on each output handshake.
module tb_seq_muxn;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [31:0] in_data4;
    logic [3:0]  in_valid4, in_ready4;
    logic        mode4;
    logic [1:0]  sel4;
    logic [7:0]  out_data4;
    logic [1:0]  out_chan4;
    logic        out_valid4, out_ready4;

    logic [23:0] in_data3;
    logic [2:0]  in_valid3, in_ready3;
    logic        mode3;
    logic [1:0]  sel3;
    logic [7:0]  out_data3;
    logic [1:0]  out_chan3;
    logic        out_valid3, out_ready3;

`ifdef SEQ_MUXN_PARITY_EN
    logic out_parity4, out_parity3;
`endif

    seq_muxn #(.WIDTH(8), .CHANNELS(4), .SEL_W(2)) u_dut4 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data4),
        .in_valid  (in_valid4),
        .in_ready  (in_ready4),
        .mode      (mode4),
        .sel       (sel4),
        .out_data  (out_data4),
        .out_chan  (out_chan4),
        .out_valid (out_valid4),
`ifdef SEQ_MUXN_PARITY_EN
        .out_parity(out_parity4),
`endif
        .out_ready (out_ready4)
    );

    seq_muxn #(.WIDTH(8), .CHANNELS(3), .SEL_W(2)) u_dut3 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data3),
        .in_valid  (in_valid3),
        .in_ready  (in_ready3),
        .mode      (mode3),
        .sel       (sel3),
        .out_data  (out_data3),
        .out_chan  (out_chan3),
        .out_valid (out_valid3),
`ifdef SEQ_MUXN_PARITY_EN
        .out_parity(out_parity3),
`endif
        .out_ready (out_ready3)
    );

    int checks   = 0;
    int failures = 0;

    logic [9:0] exp4[$];
    logic [9:0] exp3[$];
    logic [9:0] e4, e3;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every output handshake must match the oldest queued expectation.
    always @(negedge clk) begin
        if (rst_n && out_valid4 && out_ready4) begin
            if (exp4.size() == 0) begin
                chk("sb4_unexpected_beat", 32'({out_chan4, out_data4}), 32'hFFFF_FFFF);
            end else begin
                e4 = exp4.pop_front();
                chk("sb4_beat", 32'({out_chan4, out_data4}), 32'(e4));
            end
        end
        if (rst_n && out_valid3 && out_ready3) begin
            if (exp3.size() == 0) begin
                chk("sb3_unexpected_beat", 32'({out_chan3, out_data3}), 32'hFFFF_FFFF);
            end else begin
                e3 = exp3.pop_front();
                chk("sb3_beat", 32'({out_chan3, out_data3}), 32'(e3));
            end
        end
    end

    initial begin
        rst_n      = 1'b0;
        in_data4   = 32'h1312_1110;
        in_valid4  = '0;
        mode4      = 1'b0;
        sel4       = '0;
        out_ready4 = 1'b0;
        in_data3   = 24'h22_2120;
        in_valid3  = '0;
        mode3      = 1'b0;
        sel3       = '0;
        out_ready3 = 1'b0;

        // Reset state, with requests pending that must not be granted.
        step();
        step();
        in_valid4  = 4'hF;
        mode4      = 1'b1;
        out_ready4 = 1'b1;
        #1;
        chk("rst_out_valid", 32'(out_valid4), 32'd0);
        chk("rst_out_data", 32'(out_data4), 32'd0);
        chk("rst_out_chan", 32'(out_chan4), 32'd0);
        chk("rst_in_ready", 32'(in_ready4), 32'd0);
        in_valid4 = '0;
        mode4     = 1'b0;
        step();
        rst_n = 1'b1;
        step();

        // Fixed select of channel 2.
        sel4      = 2'd2;
        in_valid4 = 4'b0100;
        in_data4  = 32'h00A5_0000;
        #1;
        chk("fix_in_ready", 32'(in_ready4), 32'h4);
        exp4.push_back({2'd2, 8'hA5});
        step();
        in_valid4 = '0;
        #1;
        chk("fix_out_valid", 32'(out_valid4), 32'd1);
        chk("fix_out_data", 32'(out_data4), 32'hA5);
        chk("fix_out_chan", 32'(out_chan4), 32'd2);
`ifdef SEQ_MUXN_PARITY_EN
        chk("fix_parity", 32'(out_parity4), 32'd0);
`endif
        step();
        #1;
        chk("fix_drain", 32'(out_valid4), 32'd0);

        // Round-robin over four busy channels: 0,1,2,3,0 with no bubbles.
        mode4     = 1'b1;
        in_valid4 = 4'hF;
        in_data4  = 32'h1312_1110;
        exp4.push_back({2'd0, 8'h10});
        exp4.push_back({2'd1, 8'h11});
        exp4.push_back({2'd2, 8'h12});
        exp4.push_back({2'd3, 8'h13});
        exp4.push_back({2'd0, 8'h10});
        #1;
        chk("rr_first_ready", 32'(in_ready4), 32'h1);
        for (int i = 0; i < 5; i++) begin
            step();
            if (i == 4) in_valid4 = '0;
            #1;
            chk("rr_no_bubble", 32'(out_valid4), 32'd1);
        end
        step();
        #1;

        // Backpressure: ptr is now 1, so channel 1 wins, then stalls three cycles.
        in_valid4 = 4'b0110;
        #1;
        chk("bp_grant", 32'(in_ready4), 32'h2);
        exp4.push_back({2'd1, 8'h11});
        step();
        out_ready4 = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("bp_in_ready", 32'(in_ready4), 32'd0);
            chk("bp_data", 32'(out_data4), 32'h11);
            chk("bp_chan", 32'(out_chan4), 32'd1);
            chk("bp_valid", 32'(out_valid4), 32'd1);
            if (i < 2) begin
                step();
                #1;
            end
        end
        out_ready4 = 1'b1;
        #1;
        chk("bp_resume_ready", 32'(in_ready4), 32'h4);
        exp4.push_back({2'd2, 8'h12});
        step();
        in_valid4 = '0;
        #1;
        chk("bp_next_chan", 32'(out_chan4), 32'd2);
        chk("bp_next_valid", 32'(out_valid4), 32'd1);
        step();
        #1;

        // Three channels: wrap-and-skip and non-power-of-two pointer wrap.
        mode3      = 1'b1;
        out_ready3 = 1'b1;
        in_valid3  = 3'b010;
        #1;
        chk("rr3_first", 32'(in_ready3), 32'h2);
        exp3.push_back({2'd1, 8'h21});
        step();
        in_valid3 = 3'b011;
        #1;
        chk("wrap_skip", 32'(in_ready3), 32'h1);
        exp3.push_back({2'd0, 8'h20});
        step();
        in_valid3 = 3'b111;
        #1;
        chk("ptr_after_wrap", 32'(in_ready3), 32'h2);
        exp3.push_back({2'd1, 8'h21});
        step();
        in_valid3 = 3'b100;
        #1;
        chk("rr3_ch2", 32'(in_ready3), 32'h4);
        exp3.push_back({2'd2, 8'h22});
        step();
        in_valid3 = 3'b111;
        #1;
        chk("ptr_wrap_np2", 32'(in_ready3), 32'h1);
        exp3.push_back({2'd0, 8'h20});
        step();
        in_valid3 = '0;
        #1;
        step();
        #1;

        // Illegal select on three channels; ptr (1) must survive the fixed-mode detour.
        mode3     = 1'b0;
        sel3      = 2'd1;
        in_valid3 = 3'b111;
        #1;
        chk("fix3_sel1", 32'(in_ready3), 32'h2);
        exp3.push_back({2'd1, 8'h21});
        step();
        sel3 = 2'd3;
        #1;
        chk("illegal_sel_ready", 32'(in_ready3), 32'd0);
        chk("illegal_sel_held", 32'(out_valid3), 32'd1);
        step();
        #1;
        chk("illegal_sel_drain", 32'(out_valid3), 32'd0);
        chk("illegal_sel_ready2", 32'(in_ready3), 32'd0);
        mode3 = 1'b1;
        #1;
        chk("ptr_retained", 32'(in_ready3), 32'h2);
        exp3.push_back({2'd1, 8'h21});
        step();
        in_valid3 = '0;
        #1;
        step();
        #1;

        // Reset mid-stream: the held channel-3 beat is discarded, scan restarts at 0.
        out_ready4 = 1'b0;
        in_valid4  = 4'hF;
        #1;
        chk("pre_rst_grant", 32'(in_ready4), 32'h8);
        step();
        #1;
        chk("pre_rst_valid", 32'(out_valid4), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_valid", 32'(out_valid4), 32'd0);
        chk("rst_mid_data", 32'(out_data4), 32'd0);
        chk("rst_mid_chan", 32'(out_chan4), 32'd0);
        chk("rst_mid_ready", 32'(in_ready4), 32'd0);
        step();
        rst_n      = 1'b1;
        out_ready4 = 1'b1;
        #1;
        chk("rst_restart", 32'(in_ready4), 32'h1);
        exp4.push_back({2'd0, 8'h10});
        exp4.push_back({2'd1, 8'h11});
        step();
        step();
        in_valid4 = '0;
        #1;
        step();
        step();
        #1;

        chk("sb4_empty", 32'(exp4.size()), 32'd0);
        chk("sb3_empty", 32'(exp3.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule

// File: doc/seq_muxn.md
SEQ_MUXN -- requirements
Module: seq_muxn

Interface
REQ-001 The block SHALL take parameter WIDTH, default 8, which sets the data bits per channel (legal range 1 or more).
REQ-002 The block SHALL take parameter CHANNELS, default 4, which sets the number of input channels (legal range 2..16, power of two not required).
REQ-003 The block SHALL take parameter SEL_W, default 2, which sets the select and channel-index width and SHALL equal ceil(log2(CHANNELS)).
REQ-004 The block SHALL use one clock and an asynchronous, active-low reset; all state SHALL be clocked on the rising edge of clk.
REQ-005 clk  input  1  the single system clock.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 in_data  input  CHANNELS*WIDTH  concatenated channel data; channel k occupies bits [k*WIDTH +: WIDTH].
REQ-008 in_valid  input  CHANNELS  per-channel data-valid.
REQ-009 in_ready  output  CHANNELS  per-channel accept strobe.
REQ-010 mode  input  1  selects the arbitration mode: 0 = fixed select, 1 = round-robin scan.
REQ-011 sel  input  SEL_W  channel index used when mode=0.
REQ-012 out_data  output  WIDTH  registered selected data.
REQ-013 out_chan  output  SEL_W  index of the channel held in the output register.
REQ-014 out_valid  output  1  output register holds a beat.
REQ-015 out_ready  input  1  downstream accepts the beat.

Function
REQ-016 The block SHALL set load = ~out_valid | out_ready.
REQ-017 The block SHALL transfer a beat on an input channel only when in_valid[k] & in_ready[k] are both high.
REQ-018 At most one in_ready bit SHALL be high per cycle, and it SHALL be high only when load=1 and that channel is granted.
REQ-019 In fixed mode (mode=0), the granted channel SHALL be sel, provided in_valid[sel]=1 and sel<CHANNELS.
REQ-020 In fixed mode, when sel>=CHANNELS the block SHALL grant no channel and SHALL drive all in_ready bits to 0.
REQ-021 In round-robin mode (mode=1), the block SHALL grant the first channel with in_valid=1, searching upward from the pointer ptr and wrapping from CHANNELS-1 to 0.
REQ-022 In round-robin mode, when no channel has in_valid=1, the block SHALL grant no channel.
REQ-023 On each accepted beat in round-robin mode, ptr SHALL become (granted+1) mod CHANNELS; it SHALL wrap correctly for non-power-of-two CHANNELS.
REQ-024 ptr SHALL NOT change in fixed mode or on idle cycles.
REQ-025 On each accepted beat, out_data and out_chan SHALL be loaded on the next rising edge, giving 1-cycle latency from input handshake to out_valid=1.
REQ-026 When load=1 and no channel is granted, out_valid SHALL become 0 on the next edge.
REQ-027 When load=1 and a channel is granted, out_valid SHALL become 1 on the next edge.
REQ-028 When out_valid=1 and out_ready=0, out_data, out_chan and out_valid SHALL hold unchanged and all in_ready bits SHALL be 0 (backpressure).
REQ-029 When out_valid=1 and out_ready=1 in the same cycle as a new grant, the block SHALL pass the new beat back-to-back with no bubble, sustaining 1 beat per cycle.
REQ-030 A change of mode or sel SHALL affect only the grant in the cycle it is sampled; a beat already in the output register SHALL be unaffected, and ptr SHALL be retained across mode changes.
REQ-031 The in_ready outputs SHALL be combinational from in_valid, mode, sel, ptr, out_valid and out_ready, and SHALL have no path from in_data.

Reset
REQ-032 While rst_n=0, regardless of clk, the block SHALL force out_valid=0, out_data=0, out_chan=0 and ptr=0.
REQ-033 While rst_n=0, all in_ready bits SHALL be 0.
REQ-034 A beat pending in the output register when reset asserts SHALL be discarded.
REQ-035 After rst_n deasserts, the first grant SHALL be evaluated on the first rising clock edge.

Configuration
REQ-036 When macro SEQ_MUXN_PARITY_EN is defined, the block SHALL add output out_parity (1 bit) equal to the even parity (XOR) of the registered out_data, loaded alongside out_data.
REQ-037 With SEQ_MUXN_PARITY_EN defined, out_parity SHALL be 0 while reset is asserted.
REQ-038 When SEQ_MUXN_PARITY_EN is undefined, the out_parity port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-039 Fixed mode: mode=0, sel=2, in_valid=4'b0100, ch2 data=8'hA5, out_ready=1 -> in_ready=4'b0100, and out_data=8'hA5, out_chan=2, out_valid=1 one cycle later.
REQ-040 Round-robin: mode=1, all in_valid=1, out_ready=1, data k=8'h10+k -> out_chan sequence 0,1,2,3,0 and out_data 8'h10..8'h13, 8'h10, with no bubbles.
REQ-041 Backpressure: beat held, out_ready=0 for 3 cycles -> out_data, out_chan and out_valid stable and in_ready=0 throughout; on out_ready=1 the next beat follows next cycle.
REQ-042 Wrap and skip: CHANNELS=3, ptr=2, in_valid=3'b011 -> grant 0, then ptr=1.
REQ-043 Illegal select: CHANNELS=3, mode=0, sel=3 -> in_ready=0 and out_valid falls to 0 after the held beat drains.
REQ-044 Reset mid-stream: assert rst_n=0 between clock edges with out_valid=1 -> out_valid=0 immediately; after release the round-robin scan restarts from channel 0.
